// File: rtl/overlap_combine_acc.sv
// rtl/overlap_combine_acc.sv - GF(2) overlap combiner with burst XOR accumulation
// Optional input stage register enabled by defining OVERLAP_INREG_EN.
module overlap_combine_acc #(
  parameter int N         = 18,
  parameter int MAX_BEATS = 4,
  parameter int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [N-2:0]    b_in1,
  input  logic [N-2:0]    b_in2,
  input  logic [N-2:0]    b_in3,
  input  logic [N-2:0]    b_in4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-2:0]  out_data,
  output logic [CW-1:0]   out_beats,
  output logic            out_ovf
);

  localparam int OW = 2*N - 1;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   comb_c;
  logic [OW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            ovf_q, ovf_d;
  logic            in_fire;
  logic            in_gate;
  logic            beat_v, beat_last, beat_close;
  logic [OW-1:0]   beat_c;

  // Even bits interleave b_in1 with b_in4 shifted by one; odd bits come from b_in2^b_in3.
  always_comb begin
    comb_c         = '0;
    comb_c[0]      = b_in1[0];
    comb_c[2*N-2]  = b_in4[N-2];
    for (int i = 1; i <= N-2; i++) begin
      comb_c[2*i] = b_in1[i] ^ b_in4[i-1];
    end
    for (int i = 0; i <= N-2; i++) begin
      comb_c[2*i+1] = b_in2[i] ^ b_in3[i];
    end
  end

  assign in_fire = in_valid && in_ready;

`ifdef OVERLAP_INREG_EN
  logic            stg_v_q, stg_v_d;
  logic            stg_last_q, stg_last_d;
  logic            stg_close_q, stg_close_d;
  logic [OW-1:0]   stg_c_q, stg_c_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d, in_cnt_inc;

  assign in_cnt_inc = in_cnt_q + CW'(1);

  // Input-side beat count lets the stage know it holds the burst-closing beat.
  always_comb begin
    stg_v_d     = in_fire;
    stg_c_d     = in_fire ? comb_c : stg_c_q;
    stg_last_d  = in_fire ? in_last : stg_last_q;
    stg_close_d = in_fire ? (in_last || (in_cnt_inc == CW'(MAX_BEATS))) : stg_close_q;
    in_cnt_d    = in_cnt_q;
    if (in_fire) begin
      in_cnt_d = stg_close_d ? '0 : in_cnt_inc;
    end
    if (clr) begin
      stg_v_d     = 1'b0;
      stg_close_d = 1'b0;
      in_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_v_q     <= 1'b0;
      stg_c_q     <= '0;
      stg_last_q  <= 1'b0;
      stg_close_q <= 1'b0;
      in_cnt_q    <= '0;
    end else begin
      stg_v_q     <= stg_v_d;
      stg_c_q     <= stg_c_d;
      stg_last_q  <= stg_last_d;
      stg_close_q <= stg_close_d;
      in_cnt_q    <= in_cnt_d;
    end
  end

  assign beat_v    = stg_v_q;
  assign beat_c    = stg_c_q;
  assign beat_last = stg_last_q;
  assign in_gate   = !(stg_v_q && stg_close_q);
`else
  assign beat_v    = in_fire;
  assign beat_c    = comb_c;
  assign beat_last = in_last;
  assign in_gate   = 1'b1;
`endif

  // cnt_q is zero in IDLE, so IDLE and ACC share the same update.
  assign cnt_inc    = cnt_q + CW'(1);
  assign beat_close = beat_last || (cnt_inc == CW'(MAX_BEATS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACC: if (beat_v) state_d = beat_close ? HOLD : ACC;
        HOLD:      if (out_ready) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == HOLD);
    in_ready  = (state_q != HOLD) && in_gate;
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (state_q != HOLD && beat_v) begin
      acc_d = acc_q ^ beat_c;
      cnt_d = cnt_inc;
      ovf_d = beat_close && !beat_last;
    end else if (state_q == HOLD && out_ready) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_data  = acc_q;
  assign out_beats = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_overlap_combine_acc.sv
// tb/tb_overlap_combine_acc.sv - self-checking bench for overlap_combine_acc (N=4, MAX_BEATS=4)
module tb_overlap_combine_acc;

  localparam int N    = 4;
  localparam int MAXB = 4;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int OW   = 2*N - 1;
`ifdef OVERLAP_INREG_EN
  localparam int LAT  = 2;
`else
  localparam int LAT  = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [N-2:0] b1 = '0, b2 = '0, b3 = '0, b4 = '0;
  logic in_ready, out_valid, out_ovf;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_beats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  overlap_combine_acc #(.N(N), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .b_in1(b1), .b_in2(b2), .b_in3(b3), .b_in4(b4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beats(out_beats), .out_ovf(out_ovf)
  );

  typedef struct {
    logic [OW-1:0] data;
    int            beats;
    logic          ovf;
    int            age;
  } res_t;

  res_t          q[$];
  logic [OW-1:0] m_acc = '0;
  int            m_cnt = 0;
  bit            m_ready_pre;
  bit            exp_valid;

  // Place bit i of x at output bit 2i.
  function automatic logic [OW-1:0] spread(input logic [N-2:0] x);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < N-1; i++) r[2*i] = x[i];
    return r;
  endfunction

  function automatic logic [OW-1:0] comb_model(input logic [N-2:0] a, input logic [N-2:0] b,
                                               input logic [N-2:0] c, input logic [N-2:0] d);
    return spread(a) ^ (spread(d) << 2) ^ (spread(b ^ c) << 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst-level model: results queue up with an age that gates visibility by latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_acc = '0;
      m_cnt = 0;
    end else begin
      m_ready_pre = (q.size() == 0);
      if (clr) begin
        q.delete();
        m_acc = '0;
        m_cnt = 0;
      end else begin
        if (q.size() > 0) begin
          if (q[0].age >= LAT && out_ready) q.pop_front();
          else q[0].age = q[0].age + 1;
        end
        if (in_valid && m_ready_pre) begin
          m_acc = m_acc ^ comb_model(b1, b2, b3, b4);
          m_cnt = m_cnt + 1;
          if (in_last || m_cnt == MAXB) begin
            q.push_back('{m_acc, m_cnt, !in_last, 1});
            m_acc = '0;
            m_cnt = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_valid = (q.size() > 0) && (q[0].age >= LAT);
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() == 0});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    if (exp_valid && out_valid) begin
      chk("out_data", 32'(out_data), 32'(q[0].data));
      chk("out_beats", 32'(out_beats), 32'(q[0].beats));
      chk("out_ovf", {31'd0, out_ovf}, {31'd0, q[0].ovf});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [N-2:0] a, input logic [N-2:0] b, input logic [N-2:0] c,
                      input logic [N-2:0] d, input logic last);
    b1 = a; b2 = b; b3 = c; b4 = d;
    in_last  = last;
    in_valid = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 8) begin
      cyc();
      n++;
    end
    chk(name, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic handshake();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_beats", 32'(out_beats), 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);

    // Mapping and latency
    beat(3'b101, 3'b011, 3'b001, 3'b110, 1'b1);
    cyc();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 6) begin
      cyc();
      n++;
    end
    chk("map_latency", 32'(n), 32'(LAT));
    chk("map_data", 32'(out_data), 32'h49);
    chk("map_beats", 32'(out_beats), 32'd1);
    chk("map_ovf", {31'd0, out_ovf}, 32'd0);
    chk("model_pin_map", 32'(comb_model(3'b101, 3'b011, 3'b001, 3'b110)), 32'h49);
    handshake();
    chk("map_drop_valid", {31'd0, out_valid}, 32'd0);
    chk("map_ready_back", {31'd0, in_ready}, 32'd1);

    // Accumulate two beats
    beat(3'b101, 3'b011, 3'b001, 3'b110, 1'b0);
    cyc();
    beat(3'b111, 3'b111, 3'b111, 3'b111, 1'b1);
    cyc();
    in_valid = 1'b0;
    wait_valid("acc_valid");
    chk("acc_data", 32'(out_data), 32'h08);
    chk("acc_beats", 32'(out_beats), 32'd2);

    // Backpressure: beats presented while holding are ignored
    beat(3'b010, 3'b010, 3'b010, 3'b010, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_data", 32'(out_data), 32'h08);
    end
    handshake();
    chk("bp_drop_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);

    // Forced close at MAX_BEATS
    beat(3'b001, 3'b000, 3'b000, 3'b000, 1'b0); cyc();
    beat(3'b000, 3'b001, 3'b000, 3'b000, 1'b0); cyc();
    beat(3'b000, 3'b000, 3'b001, 3'b000, 1'b0); cyc();
    beat(3'b000, 3'b000, 3'b000, 3'b001, 1'b0); cyc();
    beat(3'b111, 3'b000, 3'b000, 3'b000, 1'b1);
    wait_valid("ovf_valid");
    chk("ovf_data", 32'(out_data), 32'h05);
    chk("ovf_beats", 32'(out_beats), 32'd4);
    chk("ovf_flag", {31'd0, out_ovf}, 32'd1);
    repeat (2) cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("ovf_fifth_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    wait_valid("fifth_valid");
    chk("fifth_data", 32'(out_data), 32'h15);
    chk("fifth_ovf", {31'd0, out_ovf}, 32'd0);
    handshake();

    // Abort mid-burst
    beat(3'b111, 3'b111, 3'b111, 3'b111, 1'b0); cyc();
    beat(3'b001, 3'b001, 3'b000, 3'b000, 1'b0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    in_valid = 1'b0;
    cyc();
    chk("clr_no_output", {31'd0, out_valid}, 32'd0);
    beat(3'b011, 3'b000, 3'b000, 3'b000, 1'b1); cyc();
    in_valid = 1'b0;
    wait_valid("clr_next_valid");
    chk("clr_next_data", 32'(out_data), 32'h05);
    chk("clr_next_beats", 32'(out_beats), 32'd1);
    handshake();

    // Asynchronous reset while holding
    beat(3'b101, 3'b011, 3'b001, 3'b110, 1'b1); cyc();
    in_valid = 1'b0;
    wait_valid("rst_hold_valid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("arst_ready", {31'd0, in_ready}, 32'd1);

    // Mixed traffic checked by the model
    for (int i = 0; i < 60; i++) begin
      b1 = 3'($urandom); b2 = 3'($urandom); b3 = 3'($urandom); b4 = 3'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = $urandom_range(0, 1) == 1;
      clr       = ($urandom_range(0, 29) == 0);
      cyc();
    end
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
